maquina_de_vendas_multi: RTL
============================

MAQUINA_DE_VENDAS_MULTI -- requirements
Module: maquina_de_vendas_multi

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_PROD, 4: product channels.
- SALDO_W, 5: credit width, in units of R$0,25.
- PRECOS, {4{5'd6}}: packed N_PROD*SALDO_W price vector; slice i is the price of product i.
- ESTOQUE_INI, 3: initial stock per product.
- TIMEOUT_CYC, 1000: inactivity limit.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low.
- moeda_in, in, 2: coin code; 00 none, 01 = 1 unit, 10 = 2 units, 11 = 4 units.
- sensor_moedas, in, 1: coin present, sampled each cycle.
- sel, in, clog2(N_PROD): product select.
- comprar, in, 1: buy request, one-cycle pulse.
- cancelar, in, 1: refund request, one-cycle pulse.
- saldo, out, SALDO_W: current credit.
- bitP, out, 1: saldo >= price[sel].
- esgotado, out, 1: stock[sel] == 0.
- libera, out, 1: dispense pulse.
- produto, out, clog2(N_PROD): dispensed index, valid with libera.
- troco, out, SALDO_W: change value, valid with troco_valid.
- troco_valid, out, 1: change pulse.
- moeda_rejeitada, out, 1: coin-return pulse.
- estado, out, 3: current state code.

Function
REQ-003 The FSM SHALL have four states: E0 IDLE=0, E1 ACUMULA=1, E2 VENDE=2, E3 TROCO=3; estado SHALL show the registered state.
REQ-004 A coin SHALL be accepted when sensor_moedas=1, moeda_in!=00 and state is E0 or E1; saldo SHALL add its value at the next edge; from E0 the FSM SHALL go to E1.
REQ-005 If saldo+coin would exceed 2^SALDO_W-1, the coin SHALL be refused, saldo SHALL be unchanged, and moeda_rejeitada SHALL pulse for 1 cycle.
REQ-006 Coins in E2 or E3 SHALL be refused with a moeda_rejeitada pulse.
REQ-007 bitP and esgotado SHALL be combinational from registered saldo, stock and the current sel.
REQ-008 In E1, comprar with bitP=1 and esgotado=0 SHALL give, at the next edge:
- state E2;
- saldo -= price[sel];
- stock[sel] -= 1;
- produto = sel.
REQ-009 In E1, comprar with bitP=0 or esgotado=1 SHALL be ignored; the state SHALL stay E1.
REQ-010 E2 SHALL last exactly 1 cycle with libera=1; it SHALL then go to E3 if saldo>0, else to E0.
REQ-011 In E1, cancelar SHALL go to E3.
REQ-012 E3 SHALL last exactly 1 cycle:
- troco = saldo and troco_valid = 1 during that cycle;
- at the next edge saldo = 0 and state E0.
REQ-013 Simultaneous events SHALL resolve as follows:
- cancelar has priority over comprar;
- comprar or cancelar has priority over a coin in the same cycle, and that coin is refused (moeda_rejeitada=1).
REQ-014 comprar or cancelar in E0 SHALL be ignored.
REQ-015 Latency SHALL be 1 cycle from comprar to libera, and 2 cycles from comprar to troco_valid when change is due.

Reset
REQ-016 reset=0 SHALL immediately force all of the following, whatever the clock or FSM state:
- state E0;
- saldo, troco and produto = 0;
- libera, troco_valid and moeda_rejeitada = 0;
- every stock = ESTOQUE_INI.
REQ-017 Credit held when reset asserts mid-transaction SHALL be discarded, with no troco_valid pulse.
REQ-018 Release of reset SHALL take effect on the first clk rising edge after deassertion.

Configuration
REQ-019 Macro MAQUINA_DE_VENDAS_TIMEOUT_EN, when defined, SHALL build an inactivity counter:
- it clears on any accepted coin, comprar or cancelar;
- it counts in E1 only;
- on reaching TIMEOUT_CYC-1 the FSM SHALL go to E3 and refund saldo as in REQ-012.
REQ-020 Without the macro, no counter logic SHALL exist, and E1 SHALL hold credit indefinitely.

Verification
REQ-021 The bench SHALL cover these directed scenarios (defaults, prices 6):
- V1: reset low, then high; coins 11,01,01 (6 units); sel=0, comprar -> bitP=1; next cycle libera=1, produto=0; saldo=0; estado 1->2->0; no troco_valid.
- V2: coins 11,11 (8 units); sel=2, comprar -> libera, then troco_valid=1 with troco=2; stock[2]=2.
- V3: 4 purchases of product 1 at 6 units each -> 4th comprar ignored; esgotado=1; estado stays 1.
- V4: saldo=28, coin 11 -> moeda_rejeitada=1, saldo stays 28; coin 11 with cancelar in the same cycle -> coin rejected, troco=28.
- V5: reset low during E2 -> libera=0 immediately, saldo=0, estado=0, stocks restored to 3.
- V6 (MAQUINA_DE_VENDAS_TIMEOUT_EN, TIMEOUT_CYC=8): coin 10 then idle -> troco_valid with troco=2 eight cycles later; without the macro, saldo=2 is held for 100 cycles.

Source files
------------

// File: rtl/maquina_de_vendas_multi.sv
// Multi-product vending FSM: coin credit, purchase, change and coin-return handling.
// Optional inactivity refund is enabled by defining MAQUINA_DE_VENDAS_TIMEOUT_EN.
module maquina_de_vendas_multi #(
    parameter int unsigned                 N_PROD      = 4,
    parameter int unsigned                 SALDO_W     = 5,
    parameter logic [N_PROD*SALDO_W-1:0]   PRECOS      = {4{5'd6}},
    parameter int unsigned                 ESTOQUE_INI = 3,
    parameter int unsigned                 TIMEOUT_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  moeda_in,
    input  logic                        sensor_moedas,
    input  logic [$clog2(N_PROD)-1:0]   sel,
    input  logic                        comprar,
    input  logic                        cancelar,
    output logic [SALDO_W-1:0]          saldo,
    output logic                        bitP,
    output logic                        esgotado,
    output logic                        libera,
    output logic [$clog2(N_PROD)-1:0]   produto,
    output logic [SALDO_W-1:0]          troco,
    output logic                        troco_valid,
    output logic                        moeda_rejeitada,
    output logic [2:0]                  estado
);

    localparam int unsigned EST_W = (ESTOQUE_INI > 0) ? $clog2(ESTOQUE_INI + 1) : 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAcumula = 3'd1,
        StVende   = 3'd2,
        StTroco   = 3'd3
    } estado_t;

    estado_t                     state_q;
    logic [SALDO_W-1:0]          saldo_q;
    logic [SALDO_W-1:0]          troco_q;
    logic [$clog2(N_PROD)-1:0]   produto_q;
    logic                        libera_q;
    logic                        troco_valid_q;
    logic                        rej_q;
    logic [EST_W-1:0]            estoque_q [N_PROD];

    logic [SALDO_W-1:0]          preco [N_PROD];
    logic [SALDO_W-1:0]          preco_sel;
    logic [2:0]                  valor_moeda;
    logic [SALDO_W:0]            soma;
    logic                        coin_ev;
    logic                        cabe;
    logic                        timeout_hit;

    for (genvar i = 0; i < N_PROD; i++) begin : g_preco
        assign preco[i] = PRECOS[i*SALDO_W +: SALDO_W];
    end

    always_comb begin
        valor_moeda = 3'd0;
        unique case (moeda_in)
            2'b01:   valor_moeda = 3'd1;
            2'b10:   valor_moeda = 3'd2;
            2'b11:   valor_moeda = 3'd4;
            default: valor_moeda = 3'd0;
        endcase
    end

    assign preco_sel = preco[sel];
    assign coin_ev   = sensor_moedas && (moeda_in != 2'b00);
    // One extra bit catches overflow past the largest representable credit.
    assign soma      = {1'b0, saldo_q} + (SALDO_W+1)'(valor_moeda);
    assign cabe      = ~soma[SALDO_W];
    assign bitP      = (saldo_q >= preco_sel);
    assign esgotado  = (estoque_q[sel] == '0);

`ifdef MAQUINA_DE_VENDAS_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] ocioso_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ocioso_q <= '0;
        end else if (state_q != StAcumula || comprar || cancelar || (coin_ev && cabe)) begin
            ocioso_q <= '0;
        end else begin
            ocioso_q <= ocioso_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == StAcumula) && (ocioso_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            saldo_q       <= '0;
            troco_q       <= '0;
            produto_q     <= '0;
            libera_q      <= 1'b0;
            troco_valid_q <= 1'b0;
            rej_q         <= 1'b0;
            for (int i = 0; i < N_PROD; i++) begin
                estoque_q[i] <= EST_W'(ESTOQUE_INI);
            end
        end else begin
            libera_q      <= 1'b0;
            troco_valid_q <= 1'b0;
            troco_q       <= '0;
            rej_q         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (coin_ev) begin
                        if (cabe) begin
                            saldo_q <= soma[SALDO_W-1:0];
                            state_q <= StAcumula;
                        end else begin
                            rej_q <= 1'b1;
                        end
                    end
                end
                StAcumula: begin
                    if (cancelar) begin
                        rej_q         <= coin_ev;
                        troco_q       <= saldo_q;
                        troco_valid_q <= 1'b1;
                        state_q       <= StTroco;
                    end else if (comprar) begin
                        rej_q <= coin_ev;
                        if (bitP && !esgotado) begin
                            saldo_q        <= saldo_q - preco_sel;
                            estoque_q[sel] <= estoque_q[sel] - EST_W'(1);
                            produto_q      <= sel;
                            libera_q       <= 1'b1;
                            state_q        <= StVende;
                        end
                    end else if (coin_ev && cabe) begin
                        saldo_q <= soma[SALDO_W-1:0];
                    end else if (timeout_hit) begin
                        rej_q         <= coin_ev;
                        troco_q       <= saldo_q;
                        troco_valid_q <= 1'b1;
                        state_q       <= StTroco;
                    end else begin
                        rej_q <= coin_ev;
                    end
                end
                StVende: begin
                    rej_q <= coin_ev;
                    if (saldo_q != '0) begin
                        troco_q       <= saldo_q;
                        troco_valid_q <= 1'b1;
                        state_q       <= StTroco;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StTroco: begin
                    rej_q   <= coin_ev;
                    saldo_q <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign saldo           = saldo_q;
    assign libera          = libera_q;
    assign produto         = produto_q;
    assign troco           = troco_q;
    assign troco_valid     = troco_valid_q;
    assign moeda_rejeitada = rej_q;
    assign estado          = state_q;

endmodule
